// File: rtl/noc_config_pkg.sv
// Shared NoC router definitions: port indices, per-VC requester states and
// the XY routing function.
package noc_config_pkg;

  localparam int NUM_PORTS = 5;
  localparam int COORD_W   = 8;

  typedef enum logic [2:0] {
    X_PLUS  = 3'd0,
    X_MINUS = 3'd1,
    Y_PLUS  = 3'd2,
    Y_MINUS = 3'd3,
    LOCAL   = 3'd4
  } noc_port_e;

  typedef enum logic [1:0] {
    VC_IDLE = 2'd0,
    VC_WAIT = 2'd1,
    VC_XFER = 2'd2
  } vc_state_e;

  // X is resolved first, then Y; coordinates compare as unsigned values.
  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] local_x,
    input logic [COORD_W-1:0] local_y
  );
    noc_port_e port;
    if (dest_x > local_x)      port = X_PLUS;
    else if (dest_x < local_x) port = X_MINUS;
    else if (dest_y > local_y) port = Y_PLUS;
    else if (dest_y < local_y) port = Y_MINUS;
    else                       port = LOCAL;
    return NUM_PORTS'(1) << port;
  endfunction

endpackage

// File: rtl/noc_vc_requester.sv
// Single-VC requester: routes the header, requests the selected output,
// forwards granted flits and releases the output on the tail.
module noc_vc_requester
  import noc_config_pkg::*;
#(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_WIDTH-1:0]   i_local_x,
  input  logic [Y_WIDTH-1:0]   i_local_y,
  input  logic                 i_valid,
  input  logic                 i_head,
  input  logic                 i_tail,
  input  logic [X_WIDTH-1:0]   i_dest_x,
  input  logic [Y_WIDTH-1:0]   i_dest_y,
  input  logic [NUM_PORTS-1:0] i_grant,
  output logic                 o_ready,
  output logic [NUM_PORTS-1:0] o_start_of_packet,
  output logic [NUM_PORTS-1:0] o_request,
  output logic [NUM_PORTS-1:0] o_end_of_packet,
  output logic [NUM_PORTS-1:0] o_free,
  output logic [NUM_PORTS-1:0] o_route,
  output logic                 o_error
);

  vc_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]  route_q, route_d;
  logic                  error_q, error_d;
  logic                  granted;

  // route_q is one-hot, so masking filters out grants on every other port.
  assign granted = i_valid && (|(i_grant & route_q));

  always_comb begin
    state_d           = state_q;
    route_d           = route_q;
    error_d           = error_q;
    o_ready           = 1'b0;
    o_start_of_packet = '0;
    o_request         = '0;
    o_end_of_packet   = '0;
    o_free            = '0;
    case (state_q)
      VC_IDLE: begin
        if (i_valid && i_head) begin
          route_d = xy_route(COORD_W'(i_dest_x), COORD_W'(i_dest_y),
                             COORD_W'(i_local_x), COORD_W'(i_local_y));
          state_d = VC_WAIT;
        end else if (i_valid) begin
          o_ready = 1'b1;
          error_d = 1'b1;
        end
      end
      VC_WAIT, VC_XFER: begin
        if (state_q == VC_WAIT) o_start_of_packet = route_q;
        if (i_valid) o_request = route_q;
        if (granted) begin
          o_ready = 1'b1;
          if (state_q == VC_XFER && i_head) error_d = 1'b1;
          if (i_tail) begin
            o_end_of_packet = route_q;
            o_free          = route_q;
            state_d         = VC_IDLE;
          end else begin
            state_d = VC_XFER;
          end
        end
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VC_IDLE;
      route_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      error_q <= error_d;
    end
  end

  assign o_route = route_q;
  assign o_error = error_q;

endmodule

// File: rtl/noc_input_port_requester.sv
// Router input port requester: one VC requester per channel, fanned out into
// flat [port][vc] control vectors (bit port*CHANNELS+vc) and [vc][port] routes.
module noc_input_port_requester
  import noc_config_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int X_WIDTH  = 2,
  parameter int Y_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [X_WIDTH-1:0]              i_local_x,
  input  logic [Y_WIDTH-1:0]              i_local_y,
  input  logic [CHANNELS-1:0]             i_valid,
  input  logic [CHANNELS-1:0]             i_head,
  input  logic [CHANNELS-1:0]             i_tail,
  input  logic [CHANNELS*X_WIDTH-1:0]     i_dest_x,
  input  logic [CHANNELS*Y_WIDTH-1:0]     i_dest_y,
  output logic [CHANNELS-1:0]             o_ready,
  output logic [NUM_PORTS*CHANNELS-1:0]   o_start_of_packet,
  output logic [NUM_PORTS*CHANNELS-1:0]   o_request,
  input  logic [NUM_PORTS*CHANNELS-1:0]   i_grant,
  output logic [NUM_PORTS*CHANNELS-1:0]   o_end_of_packet,
  output logic [NUM_PORTS*CHANNELS-1:0]   o_free,
  output logic [CHANNELS*NUM_PORTS-1:0]   o_route,
  output logic [CHANNELS-1:0]             o_error
);

  logic [NUM_PORTS-1:0] grant_vc [CHANNELS];
  logic [NUM_PORTS-1:0] sop_vc   [CHANNELS];
  logic [NUM_PORTS-1:0] req_vc   [CHANNELS];
  logic [NUM_PORTS-1:0] eop_vc   [CHANNELS];
  logic [NUM_PORTS-1:0] free_vc  [CHANNELS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
      noc_vc_requester #(
        .X_WIDTH(X_WIDTH),
        .Y_WIDTH(Y_WIDTH)
      ) u_vc (
        .clk              (clk),
        .rst              (rst),
        .i_local_x        (i_local_x),
        .i_local_y        (i_local_y),
        .i_valid          (i_valid[gi]),
        .i_head           (i_head[gi]),
        .i_tail           (i_tail[gi]),
        .i_dest_x         (i_dest_x[gi*X_WIDTH +: X_WIDTH]),
        .i_dest_y         (i_dest_y[gi*Y_WIDTH +: Y_WIDTH]),
        .i_grant          (grant_vc[gi]),
        .o_ready          (o_ready[gi]),
        .o_start_of_packet(sop_vc[gi]),
        .o_request        (req_vc[gi]),
        .o_end_of_packet  (eop_vc[gi]),
        .o_free           (free_vc[gi]),
        .o_route          (o_route[gi*NUM_PORTS +: NUM_PORTS]),
        .o_error          (o_error[gi])
      );

      for (gj = 0; gj < NUM_PORTS; gj++) begin : g_port
        assign grant_vc[gi][gj]                   = i_grant[gj*CHANNELS+gi];
        assign o_start_of_packet[gj*CHANNELS+gi] = sop_vc[gi][gj];
        assign o_request[gj*CHANNELS+gi]         = req_vc[gi][gj];
        assign o_end_of_packet[gj*CHANNELS+gi]   = eop_vc[gi][gj];
        assign o_free[gj*CHANNELS+gi]            = free_vc[gi][gj];
      end
    end
  endgenerate

endmodule

// File: tb/tb_noc_input_port_requester.sv
// Directed bench for noc_input_port_requester, local router at (1,1).
module tb_noc_input_port_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_local_x, i_local_y;
  logic [1:0]  i_valid, i_head, i_tail;
  logic [3:0]  i_dest_x, i_dest_y;
  logic [1:0]  o_ready;
  logic [9:0]  o_start_of_packet, o_request, i_grant, o_end_of_packet, o_free;
  logic [9:0]  o_route;
  logic [1:0]  o_error;

  int checks_total  = 0;
  int checks_passed = 0;

  noc_input_port_requester #(.CHANNELS(2), .X_WIDTH(2), .Y_WIDTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_local_x        (i_local_x),
    .i_local_y        (i_local_y),
    .i_valid          (i_valid),
    .i_head           (i_head),
    .i_tail           (i_tail),
    .i_dest_x         (i_dest_x),
    .i_dest_y         (i_dest_y),
    .o_ready          (o_ready),
    .o_start_of_packet(o_start_of_packet),
    .o_request        (o_request),
    .i_grant          (i_grant),
    .o_end_of_packet  (o_end_of_packet),
    .o_free           (o_free),
    .o_route          (o_route),
    .o_error          (o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-12s got=0x%0h exp=0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-12s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 2 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic flit(input int vc, input logic v, input logic h, input logic t,
                      input logic [1:0] dx, input logic [1:0] dy);
    i_valid[vc]         = v;
    i_head[vc]          = h;
    i_tail[vc]          = t;
    i_dest_x[vc*2 +: 2] = dx;
    i_dest_y[vc*2 +: 2] = dy;
  endtask

  task automatic idle_inputs();
    i_valid = '0; i_head = '0; i_tail = '0;
    i_dest_x = '0; i_dest_y = '0; i_grant = '0;
  endtask

  initial begin
    rst = 1'b1;
    i_local_x = 2'd1; i_local_y = 2'd1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_route", 32'(o_route), 32'h0);
    check("rst_error", 32'(o_error), 32'h0);
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_ctrl",  32'(o_start_of_packet | o_request | o_end_of_packet | o_free), 32'h0);

    // VC0 header to (3,1): X+ ; grant held on [0][0] = bit 0
    tick();
    flit(0, 1, 1, 0, 2'd3, 2'd1); i_grant = 10'h001;
    settle();
    check("t1_idle_rdy", 32'(o_ready), 32'h0);
    check("t1_idle_sop", 32'(o_start_of_packet), 32'h0);
    tick(); settle();
    check("t1_route",    32'(o_route), 32'h001);
    check("t1_sop",      32'(o_start_of_packet), 32'h001);
    check("t1_req",      32'(o_request), 32'h001);
    check("t1_rdy_hdr",  32'(o_ready), 32'h1);
    check("t1_eop_hdr",  32'(o_end_of_packet), 32'h0);
    tick(); flit(0, 1, 0, 0, 2'd0, 2'd0); settle();
    check("t1_sop_pay",  32'(o_start_of_packet), 32'h0);
    check("t1_rdy_pay",  32'(o_ready), 32'h1);
    check("t1_eop_pay",  32'(o_end_of_packet), 32'h0);
    tick(); flit(0, 1, 0, 1, 2'd0, 2'd0); settle();
    check("t1_rdy_tail", 32'(o_ready), 32'h1);
    check("t1_eop_tail", 32'(o_end_of_packet), 32'h001);
    check("t1_free",     32'(o_free), 32'h001);
    tick(); idle_inputs(); settle();
    check("t1_idle_req", 32'(o_request), 32'h0);

    // VC1 single-flit to (1,1): LOCAL, request [4][1] = bit 9
    flit(1, 1, 1, 1, 2'd1, 2'd1);
    tick(); settle();
    check("t2_route",    32'(o_route), 32'h201);
    for (int i = 0; i < 4; i++) begin
      i_grant = (i == 2) ? 10'h102 : 10'h000;  // wrong VC and wrong port grants
      settle();
      check("t2_wait_req", 32'(o_request), 32'h200);
      check("t2_wait_rdy", 32'(o_ready), 32'h0);
      tick();
    end
    i_grant = 10'h200; settle();
    check("t2_g_rdy",    32'(o_ready), 32'h2);
    check("t2_g_sop",    32'(o_start_of_packet), 32'h200);
    check("t2_g_eop",    32'(o_end_of_packet), 32'h200);
    check("t2_g_free",   32'(o_free), 32'h200);
    tick(); idle_inputs(); settle();
    check("t2_idle_sop", 32'(o_start_of_packet), 32'h0);

    // VC0 -> Y- (bit 6), VC1 -> Y+ (bit 5), interleaved grants
    flit(0, 1, 1, 0, 2'd1, 2'd0);
    flit(1, 1, 1, 0, 2'd1, 2'd2);
    tick(); i_grant = 10'h040; settle();
    check("t3_route",    32'(o_route), 32'h088);
    check("t3_sop",      32'(o_start_of_packet), 32'h060);
    check("t3_rdy_a",    32'(o_ready), 32'h1);
    tick(); flit(0, 1, 0, 1, 2'd0, 2'd0); i_grant = 10'h020; settle();
    check("t3_sop_b",    32'(o_start_of_packet), 32'h020);
    check("t3_req_b",    32'(o_request), 32'h060);
    check("t3_rdy_b",    32'(o_ready), 32'h2);
    check("t3_eop_b",    32'(o_end_of_packet), 32'h0);
    tick(); flit(1, 1, 0, 1, 2'd0, 2'd0); i_grant = 10'h060; settle();
    check("t3_rdy_c",    32'(o_ready), 32'h3);
    check("t3_eop_c",    32'(o_end_of_packet), 32'h060);
    check("t3_free_c",   32'(o_free), 32'h060);
    tick(); idle_inputs(); settle();
    check("t3_idle_req", 32'(o_request), 32'h0);

    // Payload in IDLE on VC0 is dropped and flagged
    flit(0, 1, 0, 0, 2'd0, 2'd0); settle();
    check("t4_drop_rdy", 32'(o_ready), 32'h1);
    check("t4_drop_sop", 32'(o_start_of_packet), 32'h0);
    tick(); idle_inputs();
    // VC1 header to (0,1): X-, bit 3 = [1][1]
    flit(1, 1, 1, 0, 2'd0, 2'd1); settle();
    check("t4_err_vc0",  32'(o_error), 32'h1);
    tick(); i_grant = 10'h008; settle();
    check("t4_route1",   32'(o_route[9:5]), 32'h02);
    check("t4_rdy_hdr",  32'(o_ready), 32'h2);
    tick(); flit(1, 1, 1, 0, 2'd3, 2'd3); settle();
    check("t4_hdr_fwd",  32'(o_ready), 32'h2);
    tick(); flit(1, 0, 0, 0, 2'd0, 2'd0); settle();
    check("t4_err_both", 32'(o_error), 32'h3);
    check("t4_bub_req",  32'(o_request), 32'h0);
    check("t4_bub_rdy",  32'(o_ready), 32'h0);
    tick(); flit(1, 1, 0, 1, 2'd0, 2'd0); settle();
    check("t4_eop",      32'(o_end_of_packet), 32'h008);
    tick(); idle_inputs(); settle();
    check("t4_err_keep", 32'(o_error), 32'h3);

    // Reset in the middle of a VC0 packet
    flit(0, 1, 1, 0, 2'd3, 2'd1); i_grant = 10'h001;
    tick(); tick(); flit(0, 1, 0, 0, 2'd0, 2'd0); settle();
    check("t5_xfer_sop", 32'(o_start_of_packet), 32'h0);
    rst = 1'b1; idle_inputs();
    tick(); rst = 1'b0; settle();
    check("t5_route",    32'(o_route), 32'h0);
    check("t5_error",    32'(o_error), 32'h0);
    check("t5_ctrl",     32'(o_start_of_packet | o_request | o_end_of_packet | o_free), 32'h0);
    // Fresh header to (2,1): X+
    flit(0, 1, 1, 1, 2'd2, 2'd1);
    tick(); settle();
    check("t5_new_rte",  32'(o_route), 32'h001);
    check("t5_new_sop",  32'(o_start_of_packet), 32'h001);
    check("t5_new_rdy",  32'(o_ready), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
